// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Request/response bundle between the decode stage (master) and
//   alu_issue_ctrl (slave).
//
//   Request:  req_valid, req_ready, opcode, funct, rs_val, rt_val, imm
//   Response: rsp_valid, rsp_ready, rsp_result, rsp_zero, rsp_err
//
// Handshake: a transfer happens on the rising edge where valid && ready.
// A producer holds valid and its payload stable until that edge, and may
// not make valid depend on ready. A consumer may raise or drop ready at
// any time.
interface alu_issue_ctrl_if #(
  parameter int WL = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [WL-1:0] rs_val;
  logic [WL-1:0] rt_val;
  logic [15:0]   imm;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [WL-1:0] rsp_result;
  logic          rsp_zero;
  logic          rsp_err;

  modport master (
    output req_valid, opcode, funct, rs_val, rt_val, imm, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, opcode, funct, rs_val, rt_val, imm, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues decoded instructions to an external combinational ALU and
//   returns the registered result. MULTU/DIVU are executed internally as
//   WL-cycle shift-add / restoring-division sequences that update HI/LO.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   bus (slave)         request / response handshake bundle
//   alu_srca/srcb/sel   operands and select to the ALU (held outside EXEC)
//   alu_out/alu_zero    ALU result and zero flag
//   hi, lo              HI/LO registers
//   dbg_state           current FSM state (state_t encoding)
module alu_issue_ctrl #(
  parameter int WL = 32,
  parameter int SL = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic [WL-1:0] alu_srca,
  output logic [WL-1:0] alu_srcb,
  output logic [SL-1:0] alu_sel,
  input  logic [WL-1:0] alu_out,
  input  logic          alu_zero,
  output logic [WL-1:0] hi,
  output logic [WL-1:0] lo,
  output logic [2:0]    dbg_state
);

  localparam int CW = $clog2(WL) + 1;

  localparam logic [SL-1:0] SEL_ADD = SL'(5'b00000);
  localparam logic [SL-1:0] SEL_SUB = SL'(5'b00001);
  localparam logic [SL-1:0] SEL_SLT = SL'(5'b00010);
  localparam logic [SL-1:0] SEL_AND = SL'(5'b10000);
  localparam logic [SL-1:0] SEL_OR  = SL'(5'b10001);
  localparam logic [SL-1:0] SEL_XOR = SL'(5'b10010);
  localparam logic [SL-1:0] SEL_NOR = SL'(5'b10011);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    K_ALU = 2'd0,
    K_MUL = 2'd1,
    K_DIV = 2'd2,
    K_ERR = 2'd3
  } kind_t;

  state_t          state;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [WL-1:0]   rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;

  // MUL: op_a = multiplicand, op_b = multiplier (shifted right).
  // DIV: op_a = divisor, op_b = dividend shifting out / quotient shifting in.
  logic [2*WL-1:0] acc;
  logic [WL:0]     rem;
  logic [WL-1:0]   op_a;
  logic [WL-1:0]   op_b;
  logic [CW-1:0]   cnt;
  logic            last_iter;

  kind_t           dec_kind;
  logic [SL-1:0]   dec_sel;
  logic [WL-1:0]   dec_srcb;

  logic [WL-1:0]   mul_addend;
  logic [WL:0]     mul_sum;
  logic [2*WL-1:0] mul_next;
  logic [WL:0]     div_shift;
  logic [WL+1:0]   div_diff;
  logic            div_neg;
  logic [WL:0]     rem_next;
  logic [WL-1:0]   quo_next;

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign dbg_state      = state;
  assign last_iter      = (cnt == CW'(WL - 1));

  always_comb begin
    dec_kind = K_ERR;
    dec_sel  = SEL_ADD;
    dec_srcb = bus.rt_val;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h20: begin dec_kind = K_ALU; dec_sel = SEL_ADD; end
          6'h22: begin dec_kind = K_ALU; dec_sel = SEL_SUB; end
          6'h2A: begin dec_kind = K_ALU; dec_sel = SEL_SLT; end
          6'h24: begin dec_kind = K_ALU; dec_sel = SEL_AND; end
          6'h25: begin dec_kind = K_ALU; dec_sel = SEL_OR;  end
          6'h26: begin dec_kind = K_ALU; dec_sel = SEL_XOR; end
          6'h27: begin dec_kind = K_ALU; dec_sel = SEL_NOR; end
          6'h19: dec_kind = K_MUL;
          6'h1B: dec_kind = K_DIV;
          default: dec_kind = K_ERR;
        endcase
      end
      6'h08: begin
        dec_kind = K_ALU;
        dec_sel  = SEL_ADD;
        dec_srcb = {{(WL-16){bus.imm[15]}}, bus.imm};
      end
      6'h0C: begin
        dec_kind = K_ALU;
        dec_sel  = SEL_AND;
        dec_srcb = {{(WL-16){1'b0}}, bus.imm};
      end
      6'h0D: begin
        dec_kind = K_ALU;
        dec_sel  = SEL_OR;
        dec_srcb = {{(WL-16){1'b0}}, bus.imm};
      end
      6'h04: begin
        dec_kind = K_ALU;
        dec_sel  = SEL_SUB;
      end
      default: dec_kind = K_ERR;
    endcase
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    mul_addend = op_b[0] ? op_a : {WL{1'b0}};
    mul_sum    = {1'b0, acc[2*WL-1:WL]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc[WL-1:1]};
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder, try subtracting the divisor, keep the difference if it did
  // not go negative. The quotient bit is the inverted borrow.
  always_comb begin
    div_shift = {rem[WL-1:0], op_b[WL-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, op_a};
    div_neg   = div_diff[WL+1];
    rem_next  = div_neg ? div_shift : div_diff[WL:0];
    quo_next  = {op_b[WL-2:0], ~div_neg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_srca     <= '0;
      alu_srcb     <= '0;
      alu_sel      <= '0;
      hi           <= '0;
      lo           <= '0;
      acc          <= '0;
      rem          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            case (dec_kind)
              K_ALU: begin
                // ALU operands only change here, so they stay put while
                // MUL/DIV or error responses are in progress.
                alu_srca <= bus.rs_val;
                alu_srcb <= dec_srcb;
                alu_sel  <= dec_sel;
                state    <= S_EXEC;
              end
              K_MUL: begin
                acc   <= '0;
                op_a  <= bus.rs_val;
                op_b  <= bus.rt_val;
                cnt   <= '0;
                state <= S_MUL;
              end
              K_DIV: begin
                rem   <= '0;
                op_a  <= bus.rt_val;
                op_b  <= bus.rs_val;
                cnt   <= '0;
                state <= S_DIV;
              end
              default: begin
                rsp_result_q <= '0;
                rsp_zero_q   <= 1'b0;
                rsp_err_q    <= 1'b1;
                rsp_valid_q  <= 1'b1;
                state        <= S_RESP;
              end
            endcase
          end else begin
            // Also raises ready on the first edge after reset release.
            req_ready_q <= 1'b1;
          end
        end

        S_EXEC: begin
          rsp_result_q <= alu_out;
          rsp_zero_q   <= alu_zero;
          rsp_err_q    <= 1'b0;
          rsp_valid_q  <= 1'b1;
          state        <= S_RESP;
        end

        S_MUL: begin
          acc  <= mul_next;
          op_b <= op_b >> 1;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            hi           <= mul_next[2*WL-1:WL];
            lo           <= mul_next[WL-1:0];
            rsp_result_q <= mul_next[WL-1:0];
            rsp_zero_q   <= (mul_next[WL-1:0] == '0);
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end
        end

        S_DIV: begin
          rem  <= rem_next;
          op_b <= quo_next;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            hi           <= rem_next[WL-1:0];
            lo           <= quo_next;
            rsp_result_q <= quo_next;
            rsp_zero_q   <= (quo_next == '0);
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state        <= S_RESP;
          end
        end

        S_RESP: begin
          // Ready rises together with the return to IDLE so the next
          // request can be taken on the very next edge.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int WL = 32;
  localparam int SL = 5;
  localparam int EW = 3 * WL + 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WL(WL)) bus ();
  logic [WL-1:0] alu_srca, alu_srcb, alu_out, hi, lo;
  logic [SL-1:0] alu_sel;
  logic          alu_zero;
  logic [2:0]    dbg_state;

  alu_issue_ctrl #(.WL(WL), .SL(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_srca  (alu_srca),
    .alu_srcb  (alu_srcb),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Reference combinational ALU.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      5'b00000: alu_out = alu_srca + alu_srcb;
      5'b00001: alu_out = alu_srca - alu_srcb;
      5'b00010: alu_out = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
      5'b10000: alu_out = alu_srca & alu_srcb;
      5'b10001: alu_out = alu_srca | alu_srcb;
      5'b10010: alu_out = alu_srca ^ alu_srcb;
      5'b10011: alu_out = ~(alu_srca | alu_srcb);
      default:  alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [WL-1:0] model_hi = '0;
  logic [WL-1:0] model_lo = '0;

  task automatic chk(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge; the bench only
  // changes rsp_ready just after a rising edge, so valid&&ready here means
  // exactly one transfer on the next rising edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", bus.rsp_result, e[EW-1 -: WL]);
          chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e[2*WL+1]});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[2*WL]});
          chk("hi", hi, e[2*WL-1 -: WL]);
          chk("lo", lo, e[WL-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.req_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) chk({name, "_req_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic [WL-1:0] rs, input logic [WL-1:0] rt, input logic [15:0] im,
                      input bit is_alu, input logic [SL-1:0] e_sel, input logic [WL-1:0] e_srcb,
                      input logic [WL-1:0] e_res, input bit e_zero, input bit e_err, input int e_lat);
    int k;
    bit busy_ready;
    wait_ready(name);
    bus.opcode = op; bus.funct = fn; bus.rs_val = rs; bus.rt_val = rt; bus.imm = im;
    bus.req_valid = 1'b1;
    exp_q.push_back({e_res, e_zero, e_err, model_hi, model_lo});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    // Junk on the request fields: they must only be sampled at accept.
    bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
    bus.rs_val = $urandom; bus.rt_val = $urandom; bus.imm = 16'($urandom);
    busy_ready = 1'b0;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1 && is_alu) begin
        chk({name, "_srca"}, alu_srca, rs);
        chk({name, "_srcb"}, alu_srcb, e_srcb);
        chk({name, "_sel"}, {27'd0, alu_sel}, {27'd0, e_sel});
      end
      if (bus.req_ready) busy_ready = 1'b1;
      if (bus.rsp_valid) break;
    end
    chk({name, "_busy_req_ready"}, {31'd0, busy_ready}, 32'd0);
    chk({name, "_latency"}, WL'(k), WL'(e_lat));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.rs_val = '0; bus.rt_val = '0; bus.imm = '0;
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_sel", {27'd0, alu_sel}, 32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    //     name     op     fn     rs            rt            imm       alu sel       srcb          result        z  e  lat
    send("add",   6'h00, 6'h20, 32'd5,        32'd7,        16'h0,    1, 5'b00000, 32'd7,        32'd12,       0, 0, 2);
    send("addi",  6'h08, 6'h00, 32'h10,       32'h99,       16'hFFF0, 1, 5'b00000, 32'hFFFFFFF0, 32'h0,        1, 0, 2);
    send("beq",   6'h04, 6'h00, 32'h55,       32'h55,       16'h0,    1, 5'b00001, 32'h55,       32'h0,        1, 0, 2);
    send("sub",   6'h00, 6'h22, 32'd3,        32'd5,        16'h0,    1, 5'b00001, 32'd5,        32'hFFFFFFFE, 0, 0, 2);
    send("slt",   6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        16'h0,    1, 5'b00010, 32'd1,        32'd1,        0, 0, 2);
    send("xor",   6'h00, 6'h26, 32'hFF00FF00, 32'h0FF00FF0, 16'h0,    1, 5'b10010, 32'h0FF00FF0, 32'hF0F0F0F0, 0, 0, 2);
    send("nor",   6'h00, 6'h27, 32'h0,        32'h0,        16'h0,    1, 5'b10011, 32'h0,        32'hFFFFFFFF, 0, 0, 2);
    send("ori",   6'h0D, 6'h00, 32'h12340000, 32'h0,        16'h8001, 1, 5'b10001, 32'h00008001, 32'h12348001, 0, 0, 2);
    send("andi",  6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0,        16'hF0F0, 1, 5'b10000, 32'h0000F0F0, 32'h0000F0F0, 0, 0, 2);

    model_hi = 32'hFFFFFFFE; model_lo = 32'h00000001;
    send("multu_max", 6'h00, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0, 0, 5'b0, 32'h0, 32'h1, 0, 0, WL + 1);
    model_hi = 32'd2; model_lo = 32'd14;
    send("divu",      6'h00, 6'h1B, 32'd100,      32'd7,        16'h0, 0, 5'b0, 32'h0, 32'd14, 0, 0, WL + 1);
    model_hi = 32'h1234; model_lo = 32'hFFFFFFFF;
    send("divu_zero", 6'h00, 6'h1B, 32'h1234,     32'd0,        16'h0, 0, 5'b0, 32'h0, 32'hFFFFFFFF, 0, 0, WL + 1);
    model_hi = 32'd1; model_lo = 32'd0;
    send("multu_2e32", 6'h00, 6'h19, 32'h10000,   32'h10000,    16'h0, 0, 5'b0, 32'h0, 32'h0, 1, 0, WL + 1);
    send("bad_funct",  6'h00, 6'h00, 32'd9,       32'd9,        16'h0, 0, 5'b0, 32'h0, 32'h0, 0, 1, 1);
    // ALU operands must be untouched by MUL/DIV/error traffic.
    @(negedge clk);
    chk("held_sel", {27'd0, alu_sel}, {27'd0, 5'b10000});
    chk("held_srcb", alu_srcb, 32'h0000F0F0);

    // Back-pressure on an error response.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send("bad_op", 6'h3F, 6'h20, 32'd1, 32'd2, 16'h0, 0, 5'b0, 32'h0, 32'h0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_err", {31'd0, bus.rsp_err}, 32'd1);
      chk("hold_result", bus.rsp_result, 32'd0);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    send("or_after_hold", 6'h00, 6'h25, 32'hA0, 32'h0B, 16'h0, 1, 5'b10001, 32'h0B, 32'hAB, 0, 0, 2);

    // Reset in the middle of a MULTU; its response must never appear.
    wait_ready("mul_abort");
    bus.opcode = 6'h00; bus.funct = 6'h19; bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'd3;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("abort_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("abort_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
    chk("abort_rsp_result", bus.rsp_result, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_srca", alu_srca, 32'd0);
    chk("abort_srcb", alu_srcb, 32'd0);
    chk("abort_sel", {27'd0, alu_sel}, 32'd0);
    chk("abort_state", {29'd0, dbg_state}, 32'd0);
    model_hi = '0; model_lo = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send("and_after_rst", 6'h00, 6'h24, 32'hF0F0, 32'hFF00, 16'h0, 1, 5'b10000, 32'hFF00, 32'hF000, 0, 0, 2);

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 32'd1, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU operand/select interface: accepts a decoded instruction request (opcode, funct, operands, immediate) over a valid/ready handshake. It drives SrcA/SrcB/sel to the ALU and registers Out/Zero into a response. MULTU/DIVU run as 32-cycle iterative sequences inside this block and update HI/LO; the ALU is not used for them. It sits between the decode stage and the ALU in the multi-cycle datapath variant.

Parameters:
WL, 32, datapath width (MULTU/DIVU iteration count equals WL)
SL, 5, ALU select width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
opcode  in  6  instruction opcode
funct  in  6  R-type function field
rs_val  in  WL  first operand
rt_val  in  WL  second operand
imm  in  16  immediate field
alu_srca  out  WL  to ALU SrcA
alu_srcb  out  WL  to ALU SrcB
alu_sel  out  SL  to ALU sel
alu_out  in  WL  from ALU Out
alu_zero  in  1  from ALU Zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_result  out  WL  result (ALU Out, or LO for MULTU/DIVU)
rsp_zero  out  1  captured Zero flag
rsp_err  out  1  unsupported instruction
hi  out  WL  HI register
lo  out  WL  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 during reset, 1 in IDLE afterwards; rsp_valid, rsp_err, rsp_zero=0; rsp_result, hi, lo, alu_srca, alu_srcb=0; alu_sel=5'b00000.
- Reset mid-operation: aborts the sequence and discards the in-flight response. HI/LO are cleared.
- sel encoding: sel[4]=0 selects arithmetic, with sel[2:0] 000 ADD, 001 SUB, 010 SLT. sel[4]=1 selects logic, with sel[3:0] 0000 AND, 0001 OR, 0010 XOR, 0011 NOR.
- Decode for opcode 0x00 (funct → sel, srcb=rt_val):
  - 0x20 ADD, 0x22 SUB, 0x2A SLT
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x19 MULTU, 0x1B DIVU
- Other opcodes:
  - 0x08 ADDI: ADD, srcb=sign-extended imm
  - 0x0C ANDI: AND, srcb=zero-extended imm
  - 0x0D ORI: OR, srcb=zero-extended imm
  - 0x04 BEQ: SUB, srcb=rt_val
- Anything else is unsupported.
- Handshake:
  - Accept happens when req_valid&&req_ready; req_ready=1 only in IDLE.
  - rsp_valid holds with stable payload until rsp_ready.
  - The return to IDLE occurs on the cycle rsp_valid&&rsp_ready.
  - A new request may be accepted no earlier than the cycle after that.
- States:
  - IDLE: on accept, register srca=rs_val, srcb and sel. Go to EXEC (ALU op), MUL, DIV, or RESP with rsp_err=1, rsp_result=0.
  - EXEC (1 cycle): alu_srca/alu_srcb/alu_sel are driven from registers. Capture alu_out→rsp_result and alu_zero→rsp_zero, then go to RESP.
  - MUL (WL cycles): unsigned shift-add. Multiplicand is rs_val; multiplier rt_val is shifted right. A 2*WL accumulator is used.
  - DIV (WL cycles): unsigned restoring division with a WL+1-bit partial remainder.
  - After the final MUL/DIV iteration, hi/lo update on the same edge, rsp_result=lo, rsp_zero=(lo==0), then go to RESP.
  - RESP: rsp_valid=1.
- Latency: ALU ops and errors raise rsp_valid at accept+2 and accept+1 cycles respectively. MULTU/DIVU raise it at accept+WL+1.
- The ALU is combinational; alu_* outputs are held at their last values outside EXEC.
- hi/lo change only at MUL/DIV completion or reset; all other ops leave them untouched.
- DIVU by zero: no special casing. The algorithm yields lo=all ones and hi=dividend; rsp_err=0.
- MULTU: {hi,lo} = full 2*WL unsigned product, no overflow flag.
- Arithmetic overflow on ADD/SUB is ignored (wraps mod 2^WL).
- req_valid deasserted while busy is ignored; inputs are sampled only on accept.

Test Plan:
- ADD: rs=5, rt=7, op=0x00/0x20 → during EXEC sel=00000, srca=5, srcb=7; rsp_result=12, rsp_zero=0, rsp_valid at accept+2.
- ADDI sign-extend: rs=0x10, imm=0xFFF0 → srcb=0xFFFFFFF0, result 0x00000000, rsp_zero=1. BEQ rs=rt=0x55 → sel=00001, rsp_zero=1.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, rsp_valid at accept+33, req_ready=0 throughout.
- DIVU: rs=100, rt=7 → lo=14, hi=2. rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234, rsp_err=0.
- Unsupported op=0x3F → rsp_err=1, rsp_result=0 at accept+1. Hold rsp_ready=0 for 5 cycles → payload stable, req_ready=0, then accept on the cycle after release.
- Assert rst_n=0 at MUL iteration 10 → all outputs at reset values immediately, hi=lo=0. After release, an AND with rs=0xF0F0, rt=0xFF00 returns 0xF000.
